// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the shared 64-bit system bus to the fetch (I) or memory-stage (D) master
// Ports: clk, reset (sync, active-high); icache_/dcache_busreq and _busidle inputs from each master;
// icache_/dcache_busgrant registered one-hot-or-zero ownership outputs.
// Tie-break: fixed priority to D by default; define BUSARB_RR_EN for round-robin on last_owner.
module bus_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic icache_busreq,
  input  logic icache_busidle,
  input  logic dcache_busreq,
  input  logic dcache_busidle,
  output logic icache_busgrant,
  output logic dcache_busgrant
);
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic tie_to_d;
`ifdef BUSARB_RR_EN
  assign tie_to_d = !last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end
  // Every release lands in IDLE, which gives the mandatory one-cycle turnaround.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: state_d = (dcache_busreq && (!icache_busreq || tie_to_d)) ? OWN_D :
                      icache_busreq ? OWN_I : IDLE;
      OWN_I: if (!icache_busreq && icache_busidle) begin
        state_d  = IDLE;
        last_d_d = 1'b0;
      end
      OWN_D: if (!dcache_busreq && dcache_busidle) begin
        state_d  = IDLE;
        last_d_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign icache_busgrant = (state_q == OWN_I);
  assign dcache_busgrant = (state_q == OWN_D);
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, directed corner sequences and random stimulus against an ownership model
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_busreq = 1'b0, icache_busidle = 1'b1;
  logic dcache_busreq = 1'b0, dcache_busidle = 1'b1;
  logic icache_busgrant, dcache_busgrant;
  int n_checks = 0;
  int n_fail = 0;
  int m_owner = 0;
  bit m_last_d = 1'b0;
  typedef struct {
    bit r, ir, ii, dr, di, ig, dg;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  bus_arbiter dut (
    .clk(clk),
    .reset(reset),
    .icache_busreq(icache_busreq),
    .icache_busidle(icache_busidle),
    .dcache_busreq(dcache_busreq),
    .dcache_busidle(dcache_busidle),
    .icache_busgrant(icache_busgrant),
    .dcache_busgrant(dcache_busgrant)
  );
  // Owner: 0 = nobody, 1 = fetch, 2 = memory stage.
  task automatic model_update(input bit r, ir, ii, dr, di);
    bit rr;
    bit busy;
`ifdef BUSARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (r) begin
      m_owner  = 0;
      m_last_d = 1'b0;
    end else if (m_owner == 0) begin
      if (ir && dr) m_owner = (rr && m_last_d) ? 1 : 2;
      else m_owner = dr ? 2 : ir ? 1 : 0;
    end else begin
      busy = (m_owner == 1) ? (ir || !ii) : (dr || !di);
      if (!busy) begin
        m_last_d = (m_owner == 2);
        m_owner  = 0;
      end
    end
  endtask
  task automatic step(input bit r, ir, ii, dr, di);
    reset = r;
    icache_busreq = ir;
    icache_busidle = ii;
    dcache_busreq = dr;
    dcache_busidle = di;
    @(posedge clk);
    model_update(r, ir, ii, dr, di);
    #1;
  endtask
  task automatic check(input string name, input bit ig, dg);
    n_checks++;
    if (icache_busgrant !== ig || dcache_busgrant !== dg) begin
      n_fail++;
      $display("FAIL %s: got ig=%b dg=%b, expected ig=%b dg=%b", name, icache_busgrant, dcache_busgrant, ig, dg);
    end
  endtask
  initial begin
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 0, 1};
    tbl[8]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].ir, tbl[i].ii, tbl[i].dr, tbl[i].di);
      check($sformatf("table[%0d]", i), tbl[i].ig, tbl[i].dg);
    end
    // Single fetch ownership with D requesting mid-ownership: no preemption, 2-cycle handover.
    step(1, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    check("single_i_c1", 1, 0);
    step(0, 1, 0, 0, 1);
    check("single_i_c2", 1, 0);
    step(0, 1, 0, 1, 0);
    check("nopreempt_c3", 1, 0);
    step(0, 1, 0, 1, 0);
    check("nopreempt_c4", 1, 0);
    step(0, 0, 1, 1, 0);
    check("release_i", 0, 0);
    step(0, 0, 1, 1, 0);
    check("handover_d", 0, 1);
    // Tie after a D release: policy-dependent.
    step(1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0);
    check("tie_first", 0, 1);
    step(0, 1, 0, 0, 1);
    check("tie_d_release", 0, 0);
    step(0, 1, 0, 1, 0);
`ifdef BUSARB_RR_EN
    check("tie_second_rr", 1, 0);
    step(0, 0, 1, 1, 0);
    check("tie_i_release_rr", 0, 0);
    step(0, 1, 0, 1, 0);
    check("tie_third_rr", 0, 1);
`else
    check("tie_second_fixed", 0, 1);
    step(0, 0, 1, 1, 0);
    check("tie_d_hold_fixed", 0, 1);
    step(0, 1, 0, 1, 0);
    check("tie_d_hold2_fixed", 0, 1);
`endif
    step(1, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check($sformatf("random[%0d]", i), m_owner == 1, m_owner == 2);
      n_checks++;
      if (icache_busgrant && dcache_busgrant) begin
        n_fail++;
        $display("FAIL exclusive[%0d]: both grants high, expected at most one", i);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
